// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter
//   Bridges the core's 64-bit load/store port to a 32-bit external memory bus
//   that allows a single outstanding command. One request is in flight at a time.
//   The adapter checks alignment and steers byte lanes for byte, half and word
//   accesses. A doubleword is split into two 32-bit beats, low word first. Load
//   data comes back sign- or zero-extended to 64 bits.
//
// Handshakes:
//   A core request transfers on a rising edge where req_valid && req_ready.
//   A bus command transfers on a rising edge where bus_valid && bus_ready.
//   Once bus_valid is raised, the command fields hold steady and bus_valid is not
//   withdrawn until that transfer happens. bus_rvalid is a one-cycle response
//   with no backpressure, and it is honoured only in WAIT0/WAIT1.
//   rsp_valid is a one-cycle pulse with no backpressure.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   req_*               core request (valid/ready, we, size, unsigned, addr, wdata)
//   rsp_valid/rdata/err completion pulse, extended load data, misalignment flag
//   bus_*               external bus command (valid/ready, we, addr, wdata, be)
//   bus_rvalid/rdata    external bus response (read data or write ack)
//   dbg_state           current FSM state, for observation only
module mem_bus_adapter #(
    parameter int XLEN   = 64,
    parameter int BUS_W  = 32,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [BUS_W-1:0]  bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_rvalid,
    input  logic [BUS_W-1:0]  bus_rdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_CMD1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next;

    // Registered request fields. The core may change req_* after acceptance.
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [BUS_W-1:0]  r_lo_word;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_double;
    logic [ADDR_W-1:0] w_base_addr;
    logic [4:0]        w_lane_shift;
    logic [BUS_W-1:0]  w_rd_shifted;
    logic [XLEN-1:0]   w_ext;
    logic [XLEN-1:0]   w_load_result;

    assign w_accept     = req_valid && (r_state == S_IDLE);
    assign w_double     = (r_size == 2'b11);
    assign w_base_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_lane_shift = {r_addr[1:0], 3'b000};

    // The alignment check uses the live request, because it decides the
    // very first transition out of IDLE.
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    // Load extension works on the word now on the bus. For a double, the
    // upper word is on the bus in WAIT1 and the lower word is held in r_lo_word.
    assign w_rd_shifted = bus_rdata >> w_lane_shift;

    always_comb begin
        w_ext = '0;
        case (r_size)
            2'b00: w_ext = r_unsigned ? {{(XLEN-8){1'b0}}, w_rd_shifted[7:0]}
                                      : {{(XLEN-8){w_rd_shifted[7]}}, w_rd_shifted[7:0]};
            2'b01: w_ext = r_unsigned ? {{(XLEN-16){1'b0}}, w_rd_shifted[15:0]}
                                      : {{(XLEN-16){w_rd_shifted[15]}}, w_rd_shifted[15:0]};
            2'b10: w_ext = r_unsigned ? {{(XLEN-32){1'b0}}, w_rd_shifted}
                                      : {{(XLEN-32){w_rd_shifted[31]}}, w_rd_shifted};
            default: w_ext = {bus_rdata, r_lo_word};
        endcase
    end

    assign w_load_result = r_we ? '0 : w_ext;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_misaligned ? S_RESP : S_CMD0;
            S_CMD0:  if (bus_ready) w_next = S_WAIT0;
            S_WAIT0: if (bus_rvalid) w_next = w_double ? S_CMD1 : S_RESP;
            S_CMD1:  if (bus_ready) w_next = S_WAIT1;
            S_WAIT1: if (bus_rvalid) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus command outputs. These are driven only in CMD states and are zero
    // elsewhere. Because they are decoded from r_state, an asynchronous reset
    // drops bus_valid at once.
    always_comb begin
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = 4'b0000;
        case (r_state)
            S_CMD0: begin
                bus_valid = 1'b1;
                bus_we    = r_we;
                bus_addr  = w_base_addr;
                // A double is 8-byte aligned, so its lane shift is zero.
                bus_wdata = r_wdata[BUS_W-1:0] << w_lane_shift;
                case (r_size)
                    2'b00:   bus_be = 4'b0001 << r_addr[1:0];
                    2'b01:   bus_be = 4'b0011 << r_addr[1:0];
                    default: bus_be = 4'b1111;
                endcase
            end
            S_CMD1: begin
                bus_valid = 1'b1;
                bus_we    = r_we;
                bus_addr  = w_base_addr + ADDR_W'(4);
                bus_wdata = r_wdata[XLEN-1:BUS_W];
                bus_be    = 4'b1111;
            end
            default: ;
        endcase
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lo_word   <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                if (w_misaligned) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
            if (r_state == S_WAIT0 && bus_rvalid) begin
                r_lo_word <= bus_rdata;
                if (!w_double) begin
                    r_rsp_rdata <= w_load_result;
                    r_rsp_err   <= 1'b0;
                end
            end
            if (r_state == S_WAIT1 && bus_rvalid) begin
                r_rsp_rdata <= w_load_result;
                r_rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Testbench for mem_bus_adapter.
//   The bench applies a table of directed requests. For each one it acts as the
//   bus slave: it holds bus_ready low for a set number of stall cycles, answers
//   each handshake with bus_rvalid after a set delay, and checks every command
//   cycle plus the final response. Two hand-written sequences drive reset into
//   the middle of a doubleword load.
module tb_mem_bus_adapter;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_adapter dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [31:0] lo;        // bus read data returned for beat 0
        logic [31:0] hi;        // bus read data returned for beat 1
        int          rstall;    // bus_ready low cycles before beat 0 is taken
        int          vstall;    // extra cycles before each bus_rvalid
        logic        exp_err;
        int          exp_beats;
        logic [63:0] exp_addr0;
        logic [31:0] exp_wd0;
        logic [31:0] exp_wd1;
        logic [3:0]  exp_be0;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: issue one request and act as the bus slave until rsp_valid appears.
    // This is entered and left at 1 time unit after a rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        int  lat;
        int  hs;
        int  stall_left;
        int  rv_left;
        bit  pend;
        bit  done;
        string tag;
        tag = $sformatf("v%0d", idx);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        tick;
        // Scramble the request so that later cycles can only use the registered copy.
        req_valid    = 1'b0;
        req_we       = ~v.we;
        req_size     = ~v.size;
        req_unsigned = ~v.uns;
        req_addr     = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata    = 64'hDEAD_DEAD_DEAD_DEAD;
        lat = 0; hs = 0; stall_left = v.rstall; rv_left = 0; pend = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            lat++;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
            if (pend) begin
                if (rv_left == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = (hs == 1) ? v.lo : v.hi;
                    pend       = 1'b0;
                end else begin
                    rv_left--;
                end
            end
            if (rsp_valid) begin
                done = 1'b1;
                chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
                chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
                chk({tag, "_err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
                chk({tag, "_beats"}, 64'(hs), 64'(v.exp_beats));
            end else if (bus_valid) begin
                chk($sformatf("%s_b%0d_addr", tag, hs), bus_addr,
                    (hs == 0) ? v.exp_addr0 : v.exp_addr0 + 64'd4);
                chk($sformatf("%s_b%0d_wdata", tag, hs), {32'd0, bus_wdata},
                    {32'd0, (hs == 0) ? v.exp_wd0 : v.exp_wd1});
                chk($sformatf("%s_b%0d_be", tag, hs), {60'd0, bus_be},
                    {60'd0, (hs == 0) ? v.exp_be0 : 4'hF});
                chk($sformatf("%s_b%0d_we", tag, hs), {63'd0, bus_we}, {63'd0, v.we});
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    bus_ready = 1'b1;
                    pend      = 1'b1;
                    rv_left   = v.vstall;
                    hs++;
                end
            end
            if (!done) tick;
        end
        if (!done) chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        tick;
        chk({tag, "_pulse_one_cycle"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_back_to_idle"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_rdata_held"}, rsp_rdata, v.exp_rdata);
    endtask

    // Start a doubleword load, then assert reset in CMD1 (bus_valid high) or in WAIT1.
    task automatic reset_mid(input bit in_wait1);
        string tag;
        tag = in_wait1 ? "rst_wait1" : "rst_cmd1";
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b11;
        req_unsigned = 1'b0;
        req_addr     = 64'hC000;
        req_wdata    = 64'd0;
        chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
        tick;
        req_valid = 1'b0;
        bus_ready = 1'b1;               // CMD0 handshake
        tick;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b1;              // WAIT0 response
        bus_rdata  = 32'h1357_9BDF;
        tick;
        bus_rvalid = 1'b0;
        chk({tag, "_cmd1_valid"}, {63'd0, bus_valid}, 64'd1);
        chk({tag, "_cmd1_addr"}, bus_addr, 64'hC004);
        if (in_wait1) begin
            bus_ready = 1'b1;
            tick;
            bus_ready = 1'b0;
            chk({tag, "_in_wait"}, {63'd0, bus_valid}, 64'd0);
        end
        #2 reset = 1'b0;
        #1;
        chk({tag, "_valid_drop"}, {63'd0, bus_valid}, 64'd0);
        chk({tag, "_ready_async"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_rdata_clr"}, rsp_rdata, 64'd0);
        bus_rvalid = 1'b1;              // late ack for the abandoned beat
        bus_rdata  = 32'h2468_ACE0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("%s_no_rsp%0d", tag, i), {63'd0, rsp_valid}, 64'd0);
        end
        #2 reset = 1'b1;
        tick;
        // A stray rvalid in IDLE must be ignored.
        chk({tag, "_stray_rvalid_idle"}, {63'd0, req_ready}, 64'd1);
        chk({tag, "_stray_rvalid_rsp"}, {63'd0, rsp_valid}, 64'd0);
        bus_rvalid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 64'h1003, 64'h0, 32'h80AABBCC, 32'h0, 0, 0,
                     1'b0, 1, 64'h1000, 32'h0, 32'h0, 4'h8, 64'hFFFF_FFFF_FFFF_FF80, 3};
        vecs[1]  = '{1'b0, 2'd2, 1'b1, 64'h2004, 64'h0, 32'hDEADBEEF, 32'h0, 0, 0,
                     1'b0, 1, 64'h2004, 32'h0, 32'h0, 4'hF, 64'h0000_0000_DEAD_BEEF, 3};
        vecs[2]  = '{1'b1, 2'd3, 1'b0, 64'h3000, 64'h1122_3344_5566_7788, 32'h0, 32'h0, 0, 0,
                     1'b0, 2, 64'h3000, 32'h55667788, 32'h11223344, 4'hF, 64'h0, 5};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 64'h1001, 64'h0, 32'h0, 32'h0, 0, 0,
                     1'b1, 0, 64'h0, 32'h0, 32'h0, 4'h0, 64'h0, 1};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 64'h4002, 64'hABCD, 32'h0, 32'h0, 3, 0,
                     1'b0, 1, 64'h4000, 32'hABCD0000, 32'h0, 4'hC, 64'h0, 6};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 64'h5006, 64'h0, 32'h80011234, 32'h0, 0, 0,
                     1'b0, 1, 64'h5004, 32'h0, 32'h0, 4'hC, 64'hFFFF_FFFF_FFFF_8001, 3};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 64'h6001, 64'h0, 32'h000080FF, 32'h0, 0, 1,
                     1'b0, 1, 64'h6000, 32'h0, 32'h0, 4'h2, 64'h80, 4};
        vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'h7008, 64'h0, 32'h89ABCDEF, 32'h01234567, 2, 0,
                     1'b0, 2, 64'h7008, 32'h0, 32'h0, 4'hF, 64'h0123_4567_89AB_CDEF, 7};
        vecs[8]  = '{1'b0, 2'd3, 1'b0, 64'h7004, 64'h0, 32'h0, 32'h0, 0, 0,
                     1'b1, 0, 64'h0, 32'h0, 32'h0, 4'h0, 64'h0, 1};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 64'h8000, 64'h0, 32'h80000000, 32'h0, 0, 0,
                     1'b0, 1, 64'h8000, 32'h0, 32'h0, 4'hF, 64'hFFFF_FFFF_8000_0000, 3};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 64'h8002, 64'h0, 32'h0, 32'h0, 0, 0,
                     1'b1, 0, 64'h0, 32'h0, 32'h0, 4'h0, 64'h0, 1};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 64'h9002, 64'hA5, 32'h0, 32'h0, 0, 0,
                     1'b0, 1, 64'h9000, 32'h00A50000, 32'h0, 4'h4, 64'h0, 3};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 64'hA001, 64'h0, 32'h00007F00, 32'h0, 0, 0,
                     1'b0, 1, 64'hA000, 32'h0, 32'h0, 4'h2, 64'h7F, 3};
        vecs[13] = '{1'b0, 2'd1, 1'b1, 64'hB002, 64'h0, 32'hFFFE0000, 32'h0, 0, 0,
                     1'b0, 1, 64'hB000, 32'h0, 32'h0, 4'hC, 64'hFFFE, 3};
        vecs[14] = '{1'b1, 2'd2, 1'b0, 64'hD000, 64'hFFFF_FFFF_CAFE_F00D, 32'h0, 32'h0, 1, 2,
                     1'b0, 1, 64'hD000, 32'hCAFEF00D, 32'h0, 4'hF, 64'h0, 6};

        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        bus_ready    = 1'b0;
        bus_rvalid   = 1'b0;
        bus_rdata    = 32'd0;
        tick;
        tick;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
        chk("rst_bus_we", {63'd0, bus_we}, 64'd0);
        chk("rst_bus_addr", bus_addr, 64'd0);
        chk("rst_bus_wdata", {32'd0, bus_wdata}, 64'd0);
        chk("rst_bus_be", {60'd0, bus_be}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        reset_mid(1'b0);
        run_vec(100, vecs[0]);
        reset_mid(1'b1);
        run_vec(101, vecs[12]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
